out_port_bank: RTL

//  Multi-channel buffered output port; parametrised successor of the single latched OutPort.
//  The datapath's out instruction (Gra/Rout drives bus, out_en strobes) pushes {channel, data} into a shared FIFO.

---
 rtl/out_port_bank_if.sv | 32 +++
 rtl/out_port_bank.sv | 125 ++++++++++++
 2 files changed

// File: rtl/out_port_bank_if.sv
// Bus-side and device-side signals of the buffered multi-channel output port.
// The master modport is the CPU/device side; the slave modport is the port bank itself.
interface out_port_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0]        bus_in;
  logic [CH_W-1:0]              ch_sel;
  logic                         out_en;
  logic                         stall;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH-1:0]            ch_ready;
  logic [LVL_W-1:0]             fifo_level;
  logic                         err_ovf;
  logic                         err_ch;
  logic                         err_clr;

  modport master (
    output bus_in, ch_sel, out_en, ch_ready, err_clr,
    input  stall, ch_data, ch_valid, fifo_level, err_ovf, err_ch
  );

  modport slave (
    input  bus_in, ch_sel, out_en, ch_ready, err_clr,
    output stall, ch_data, ch_valid, fifo_level, err_ovf, err_ch
  );
endinterface

// File: rtl/out_port_bank.sv
// Multi-channel buffered output port: out instructions push {channel, word} into a shared FIFO
// that drains in strict order into per-channel holding registers with valid/ready handshakes.
module out_port_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  out_port_bank_if.slave bank
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CH_W:0]      CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Channel numbers are CH_W bits wide but may exceed NUM_CH-1 when NUM_CH is not a power of two.
  function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
    return ({1'b0, ch} < CH_LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0]        r_mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]              r_mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [LVL_W-1:0]             r_level;
  logic [NUM_CH*DATA_WIDTH-1:0] r_ch_data;
  logic [NUM_CH-1:0]            r_ch_valid;
  logic                         r_err_ovf;
  logic                         r_err_ch;

  logic                         w_full;
  logic                         w_empty;
  logic                         w_ch_ok;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_head_busy;
  logic [CH_W-1:0]              w_head_ch;
  logic [DATA_WIDTH-1:0]        w_head_data;
  logic [NUM_CH-1:0]            w_pop_sel;

  assign w_full      = (r_level == LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_ch_ok     = ch_in_range(bank.ch_sel);
  // Full blocks the push even when a pop frees an entry on the same edge.
  assign w_push      = bank.out_en & ~w_full & w_ch_ok;
  assign w_head_ch   = r_mem_ch[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_pop       = ~w_empty & ~w_head_busy;

  // Head is blocked only by its own channel holding an unaccepted word (head-of-line by design).
  always_comb begin
    w_head_busy = 1'b0;
    w_pop_sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_head_ch == CH_W'(c)) begin
        w_head_busy  = r_ch_valid[c] & ~bank.ch_ready[c];
        w_pop_sel[c] = w_pop;
      end
    end
  end

  // ---- FIFO storage (contents need no reset; level and pointers define validity) ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bank.bus_in;
      r_mem_ch[r_wr_ptr]   <= bank.ch_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---- Channel holding registers ----
  // A pop into a channel that is handing off on the same edge replaces the word without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_data  <= '0;
      r_ch_valid <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_pop_sel[c]) begin
          r_ch_data[c*DATA_WIDTH +: DATA_WIDTH] <= w_head_data;
          r_ch_valid[c]                         <= 1'b1;
        end else if (r_ch_valid[c] & bank.ch_ready[c]) begin
          r_ch_valid[c] <= 1'b0;
        end
      end
    end
  end

  // ---- Sticky error flags: a new event wins over a same-edge clear ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_ch  <= 1'b0;
    end else begin
      if (bank.out_en & w_full)        r_err_ovf <= 1'b1;
      else if (bank.err_clr)           r_err_ovf <= 1'b0;
      if (bank.out_en & ~w_ch_ok)      r_err_ch  <= 1'b1;
      else if (bank.err_clr)           r_err_ch  <= 1'b0;
    end
  end

  assign bank.stall      = w_full;
  assign bank.ch_data    = r_ch_data;
  assign bank.ch_valid   = r_ch_valid;
  assign bank.fifo_level = r_level;
  assign bank.err_ovf    = r_err_ovf;
  assign bank.err_ch     = r_err_ch;
endmodule
